// File: rtl/uart_tx_byte_feeder.sv
// Byte FIFO plus issue sequencer in front of the constant-baud UART transmitter.
// Drives the tx_start/tx_data handshake one byte at a time from the transmitter's registered feedback.
module uart_tx_byte_feeder #(
  parameter int fifo_depth = 16,
  parameter int gap_cycles = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [7:0]                  wr_data,
  input  logic                        clr_overflow,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(fifo_depth):0] count,
  output logic                        overflow,
  output logic                        busy,
  output logic                        tx_start,
  output logic [7:0]                  tx_data,
  input  logic                        tx_done,
  input  logic                        tx_idle
);

  localparam int AW = $clog2(fifo_depth);
  localparam int PW = AW + 1;
  localparam int GW = $clog2(gap_cycles + 2) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_DONE, GAP} state_t;

  logic [7:0]    mem [fifo_depth];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [GW-1:0] gap_cnt;
  state_t        state;
  logic          push, pop;

  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (count == PW'(fifo_depth));
  assign busy  = (state != IDLE) || !empty;
  assign push  = wr_en && !full;
  assign pop   = (state == IDLE) && !empty && tx_idle;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      // a dropped write beats a same-cycle clear
      if (wr_en && full) overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= 8'h00;
      gap_cnt  <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (pop) begin
          tx_data  <= mem[rd_ptr[AW-1:0]];
          tx_start <= 1'b1;
          state    <= WAIT_DONE;
        end
        WAIT_DONE: if (tx_done) begin
          // the extra count covers the clock where tx_idle still shows the finished frame
          gap_cnt <= GW'(gap_cycles + 1);
          state   <= GAP;
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
          if (gap_cnt == '0 && tx_idle) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_byte_feeder.md
# uart_tx_byte_feeder

Byte FIFO and issue sequencer that sits directly upstream of the constant-baud UART transmitter. Producers in the DDS control path (command responders, status reporters) write bytes at system-clock rate. The block buffers them and drives the transmitter's `tx_start`/`tx_data` handshake one byte at a time, using the transmitter's registered `tx_done`/`tx_idle` feedback. It exists so upstream logic never has to track UART timing.

## Interface
- `fifo_depth`, 16 — number of byte slots; must be a power of two and at least 2.
- `gap_cycles`, 0 — extra idle clocks enforced between one byte's `tx_done` and the next `tx_start`; 0 means no extra gap.
- `clk` input 1 — system clock; single clock domain.
- `rst` input 1 — synchronous, active-high reset.
- `wr_en` input 1 — write strobe; one byte per cycle.
- `wr_data` input 8 — byte to enqueue.
- `clr_overflow` input 1 — clears the sticky `overflow` flag.
- `full` output 1 — FIFO holds `fifo_depth` bytes.
- `empty` output 1 — FIFO holds 0 bytes.
- `count` output clog2(fifo_depth)+1 — current FIFO occupancy.
- `overflow` output 1 — sticky; set when a write is dropped.
- `busy` output 1 — high when the FSM is not IDLE or the FIFO is not empty.
- `tx_start` output 1 — one-cycle start pulse to the transmitter.
- `tx_data` output 8 — byte for the transmitter; stable from the `tx_start` cycle until `tx_done`.
- `tx_done` input 1 — registered one-cycle completion pulse from the transmitter.
- `tx_idle` input 1 — registered idle level from the transmitter; lags its internal state by one cycle.

## Operation
- **FIFO:** circular buffer with read/write pointers of clog2(fifo_depth)+1 bits; the MSB distinguishes full from empty. Pointers wrap modulo 2·fifo_depth. `full`, `empty` and `count` are derived from the registered pointers.
- **Write:**
  - Accepted when `wr_en`=1 and `full`=0, where `full` is the pre-edge value.
  - A write while full is dropped and sets `overflow`, even if a pop occurs on the same edge.
- **Read (pop):** performed only by the FSM on the IDLE→WAIT_DONE transition.
- **Simultaneous push and pop (not full):** both take effect; `count` is unchanged.
- **Write into an empty FIFO:** the byte is not visible to the FSM until the next cycle; there is no fall-through.
- **overflow:**
  - Cleared by `rst` or by `clr_overflow`.
  - If `clr_overflow` and a dropped write occur on the same edge, `overflow` ends at 1 (set wins).
- **FSM states:**
  - IDLE: when `empty`=0 and `tx_idle`=1, pop the head byte into `tx_data`, pulse `tx_start` for one cycle, and go to WAIT_DONE.
  - WAIT_DONE: ignore `tx_idle`. It stays high for up to two cycles after the start, because the transmitter's idle output is registered. On `tx_done`=1, load the gap counter and go to GAP.
  - GAP: wait until the gap counter has counted `gap_cycles` clocks and `tx_idle`=1, then go to IDLE.
- **tx_done outside WAIT_DONE:** ignored.
- **Reset (also mid-operation):** FSM to IDLE, pointers to 0 (FIFO flushed), gap counter cleared. The transmitter shares `rst`, so an in-flight frame is abandoned.

## Timing
- **Reset values:** `tx_start`=0, `tx_data`=0x00, `full`=0, `empty`=1, `count`=0, `overflow`=0, `busy`=0.
- **All outputs are registered or decoded from registers;** there is no combinational path from inputs to outputs.
- **Write latency:** a write on edge N makes `count`/`empty` update after edge N.
- **First-byte latency:** with the FIFO and transmitter idle, the FSM pops on edge N+1. `tx_start`=1 and `tx_data` are valid for cycle N+1 only (the pulse); `tx_data` then holds its value.
- **Back-to-back bytes (`gap_cycles`=0):**
  - `tx_done` is sampled on edge D.
  - The transmitter's `tx_idle` returns to 1 after edge D+1.
  - The FSM re-enters IDLE at edge D+2 and issues the next `tx_start` after edge D+3.
- **Gap accounting:** the gap counter counts the clocks spent in GAP. The next `tx_start` is therefore no earlier than D+3+`gap_cycles`, and later if `tx_idle` is still 0.
- **busy:** falls in the cycle after the FSM returns to IDLE with the FIFO empty.

## Test plan
- **Reset:** assert `rst` for 3 cycles → all outputs at their reset values; `tx_start` never pulses while `tx_idle`=1 and the FIFO is empty.
- **Single byte:**
  - Stimulus: write 0xA5; transmitter model at 100 MHz / 115200 baud (868 clocks per bit).
  - Required: exactly one `tx_start` pulse two cycles after the write, with `tx_data`=0xA5.
  - Required: the serial line decodes as 0xA5; `busy` falls after `tx_done` + 2.
- **Burst:**
  - Stimulus: write 0x01..0x05 on consecutive cycles.
  - Required: `count` rises to 5; bytes are sent in order 0x01..0x05.
  - Required: each `tx_start` is exactly 3 cycles after the previous `tx_done`.
  - Required: `count` decrements on each pop; `empty`=1 after the last pop.
- **Overflow:**
  - Stimulus: with `fifo_depth`=16 and the transmitter held busy, write 17 bytes.
  - Required: `full`=1 after the 16th write; the 17th byte is dropped and `overflow`=1.
  - Required: all 16 accepted bytes are transmitted.
  - Stimulus: pulse `clr_overflow` → required: `overflow`=0.
- **Simultaneous push and pop:** with `count`=3, write on the exact pop edge → `count` stays 3 and the new byte is sent last.
- **Gap and reset:**
  - Stimulus: `gap_cycles`=10, write 2 bytes → required: second `tx_start` is at `tx_done` + 13.
  - Stimulus: assert `rst` mid-frame with 4 bytes queued → required: `count`=0 and no further `tx_start` pulses.
